// File: rtl/br_seq_ctrl_if.sv
// Sequencer bus: instruction-memory fetch, execute-stage issue and flag write-back.
// master = sequencer side, slave = memory/execute side.
interface br_seq_ctrl_if #(
    parameter int unsigned AW = 8
) ();
    logic          run;
    logic [AW-1:0] imem_addr;
    logic          imem_req;
    logic          imem_ack;
    logic [15:0]   imem_data;
    logic [15:0]   ir_out;
    logic          ir_valid;
    logic          ir_ready;
    logic          flag_we;
    logic [2:0]    flag_in;
    logic [2:0]    znc_out;
    logic [AW-1:0] pc_out;
    logic          br_taken;
    logic          halted;

    modport master (
        input  run,
        input  imem_ack,
        input  imem_data,
        input  ir_ready,
        input  flag_we,
        input  flag_in,
        output imem_addr,
        output imem_req,
        output ir_out,
        output ir_valid,
        output znc_out,
        output pc_out,
        output br_taken,
        output halted
    );

    modport slave (
        output run,
        output imem_ack,
        output imem_data,
        output ir_ready,
        output flag_we,
        output flag_in,
        input  imem_addr,
        input  imem_req,
        input  ir_out,
        input  ir_valid,
        input  znc_out,
        input  pc_out,
        input  br_taken,
        input  halted
    );
endinterface

// File: rtl/br_seq_ctrl.sv
// Instruction sequencer: owns PC and Z/N/C flags, fetches over req/ack, resolves
// branches locally and issues all other instructions over valid/ready.
module br_seq_ctrl #(
    parameter int unsigned   AW        = 8,
    parameter logic [AW-1:0] RESET_VEC = '0,
    parameter logic [3:0]    BR_OP     = 4'hC,
    parameter logic [3:0]    HALT_OP   = 4'hF
) (
    input logic           clk_i,
    input logic           reset_ni,
    br_seq_ctrl_if.master bus_io
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StEval,
        StIssue,
        StHalt
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [2:0]    znc_q, znc_d;
    logic [15:0]   ir_q, ir_d;

    logic [2:0]    flags_eff;
    logic [2:0]    br_mode;
    logic          br_cond;
    logic [15:0]   br_off;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] pc_br;
    logic [3:0]    fetch_op;

    // Flags written this cycle are forwarded into the branch decision.
    assign flags_eff = bus_io.flag_we ? bus_io.flag_in : znc_q;
    assign br_mode   = ir_q[10:8];
    assign fetch_op  = bus_io.imem_data[15:12];

    always_comb begin
        if (ir_q[11]) begin
            br_cond = (|(br_mode & flags_eff)) || (br_mode == 3'b111);
        end else begin
            br_cond = (|(br_mode ^ flags_eff)) || (br_mode == 3'b000);
        end
    end

    // Offset is sign-extended to 16 bits and truncated to AW (AW must lie in 8..16).
    assign br_off = {{8{ir_q[7]}}, ir_q[7:0]};
    assign pc_inc = pc_q + AW'(1);
    assign pc_br  = pc_inc + br_off[AW-1:0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        znc_d   = bus_io.flag_we ? bus_io.flag_in : znc_q;

        unique case (state_q)
            StIdle: begin
                if (bus_io.run) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (bus_io.imem_ack) begin
                    ir_d = bus_io.imem_data;
                    if (fetch_op == HALT_OP) begin
                        state_d = StHalt;
                    end else if (fetch_op == BR_OP) begin
                        state_d = StEval;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StEval: begin
                pc_d    = br_cond ? pc_br : pc_inc;
                state_d = bus_io.run ? StFetch : StIdle;
            end
            StIssue: begin
                if (bus_io.ir_ready) begin
                    pc_d    = pc_inc;
                    state_d = bus_io.run ? StFetch : StIdle;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= StIdle;
            pc_q    <= RESET_VEC;
            znc_q   <= 3'b000;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            znc_q   <= znc_d;
            ir_q    <= ir_d;
        end
    end

    // Outputs decode straight from state so reset clears them without a clock edge.
    assign bus_io.imem_req  = (state_q == StFetch);
    assign bus_io.imem_addr = pc_q;
    assign bus_io.ir_out    = ir_q;
    assign bus_io.ir_valid  = (state_q == StIssue);
    assign bus_io.znc_out   = znc_q;
    assign bus_io.pc_out    = pc_q;
    assign bus_io.br_taken  = (state_q == StEval) && br_cond;
    assign bus_io.halted    = (state_q == StHalt);

    property p_req_held;
        @(posedge clk_i) disable iff (!reset_ni)
            bus_io.imem_req && !bus_io.imem_ack |=> bus_io.imem_req;
    endproperty

    property p_issue_stable;
        @(posedge clk_i) disable iff (!reset_ni)
            bus_io.ir_valid && !bus_io.ir_ready |=> bus_io.ir_valid && $stable(bus_io.ir_out);
    endproperty

    property p_br_pulse;
        @(posedge clk_i) disable iff (!reset_ni) bus_io.br_taken |=> !bus_io.br_taken;
    endproperty

    property p_halt_sticky;
        @(posedge clk_i) disable iff (!reset_ni) bus_io.halted |=> bus_io.halted;
    endproperty

    a_req_held:     assert property (p_req_held);
    a_issue_stable: assert property (p_issue_stable);
    a_br_pulse:     assert property (p_br_pulse);
    a_halt_sticky:  assert property (p_halt_sticky);

endmodule
